spi: RTL and testbench

SPI -- requirements
Module: spi

---
 rtl/spi.sv | 161 ++++++++++++++++
 tb/tb_spi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi.sv
// Mode-0 SPI master: one W_DATA-bit word per load, MSB first, spi_clk from a CLK_DIV down-counter.
// Build option: define SPI_LOOPBACK_EN to feed MOSI_out back into the receive shifter instead of MISO_in.
//
// state | meaning
// IDLE  | waiting for a load; transmit_ready_MOSI high, spi_clk low, MOSI_out holds last bit
// SHIFT | spi_clk running; sample on rise, shift out on fall
// DONE  | one cycle: MISO_data updated, data_in_valid high
module spi #(
    parameter int W_DATA  = 32,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              transmit_ready_MOSI,
    output logic              transmit_ready_MISO,
    input  logic [W_DATA-1:0] MOSI_data,
    input  logic              data_transmit_valid,
    output logic [W_DATA-1:0] MISO_data,
    output logic              data_in_valid,
    input  logic              MISO_in,
    output logic              spi_clk,
    output logic              MOSI_out
);

    localparam int          CNT_W      = (W_DATA > 2) ? $clog2(W_DATA) : 1;
    localparam logic [7:0]  DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BITS_RELOAD = CNT_W'(W_DATA - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_div;
    logic [CNT_W-1:0]   r_bits;
    logic [W_DATA-1:0]  r_tx;
    logic [W_DATA-1:0]  r_rx;
    logic               r_spi_clk;
    logic               r_mosi;
    logic [W_DATA-1:0]  r_miso_data;
    logic               r_din_valid;
    logic               r_rdy_miso;
    logic               r_rdy_mosi;

    logic               w_load;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_last;
    logic               w_sample;

`ifdef SPI_LOOPBACK_EN
    logic               w_unused_miso_in;
    assign w_unused_miso_in = MISO_in;
    assign w_sample         = r_mosi;
`else
    assign w_sample         = MISO_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A tick is the divider terminal count; it marks every spi_clk edge.
    always_comb begin
        w_load = (r_state == ST_IDLE) && data_transmit_valid;
        w_tick = (r_state == ST_SHIFT) && (r_div == 8'd0);
        w_rise = w_tick && !r_spi_clk;
        w_fall = w_tick && r_spi_clk;
        w_last = w_fall && (r_bits == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= 8'd0;
            r_spi_clk <= 1'b0;
        end else if (w_load) begin
            r_div     <= DIV_RELOAD;
            r_spi_clk <= 1'b0;
        end else if (w_tick) begin
            r_div     <= DIV_RELOAD;
            r_spi_clk <= ~r_spi_clk;
        end else if (r_state == ST_SHIFT) begin
            r_div     <= r_div - 8'd1;
        end
    end

    // r_bits counts remaining spi_clk falls; zero means the current fall is the last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bits <= '0;
            r_tx   <= '0;
            r_mosi <= 1'b0;
        end else if (w_load) begin
            r_bits <= BITS_RELOAD;
            r_tx   <= MOSI_data;
            r_mosi <= MOSI_data[W_DATA-1];
        end else if (w_fall && !w_last) begin
            r_bits <= r_bits - 1'b1;
            r_tx   <= r_tx << 1;
            r_mosi <= r_tx[W_DATA-2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx <= '0;
        end else if (w_load) begin
            r_rx <= '0;
        end else if (w_rise) begin
            r_rx <= {r_rx[W_DATA-2:0], w_sample};
        end
    end

    // Completion flags are set on the edge entering DONE so they are visible during DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miso_data <= '0;
            r_din_valid <= 1'b0;
            r_rdy_miso  <= 1'b0;
            r_rdy_mosi  <= 1'b1;
        end else begin
            r_din_valid <= 1'b0;
            r_rdy_mosi  <= (w_state_nxt == ST_IDLE);
            if (w_load) begin
                r_rdy_miso <= 1'b0;
            end
            if (w_last) begin
                r_miso_data <= r_rx;
                r_din_valid <= 1'b1;
                r_rdy_miso  <= 1'b1;
            end
        end
    end

    assign transmit_ready_MOSI = r_rdy_mosi;
    assign transmit_ready_MISO = r_rdy_miso;
    assign MISO_data           = r_miso_data;
    assign data_in_valid       = r_din_valid;
    assign spi_clk             = r_spi_clk;
    assign MOSI_out            = r_mosi;

endmodule

// File: tb/tb_spi.sv
// Scoreboard bench for spi: the driver queues expected words, a monitor checks each data_in_valid pulse.
// Define SPI_LOOPBACK_EN for both bench and design to exercise the loopback build.
module tb_spi;

    localparam int W         = 32;
    localparam int DIV       = 2;
    localparam int SHIFT_CYC = 2 * W * DIV;
`ifdef SPI_LOOPBACK_EN
    localparam bit LOOPBACK  = 1'b1;
`else
    localparam bit LOOPBACK  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          transmit_ready_MOSI;
    logic          transmit_ready_MISO;
    logic [W-1:0]  MOSI_data = '0;
    logic          data_transmit_valid = 1'b0;
    logic [W-1:0]  MISO_data;
    logic          data_in_valid;
    logic          MISO_in = 1'b0;
    logic          spi_clk;
    logic          MOSI_out;

    always #5 clk = ~clk;

    spi #(.W_DATA(W), .CLK_DIV(DIV)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .transmit_ready_MOSI (transmit_ready_MOSI),
        .transmit_ready_MISO (transmit_ready_MISO),
        .MOSI_data           (MOSI_data),
        .data_transmit_valid (data_transmit_valid),
        .MISO_data           (MISO_data),
        .data_in_valid       (data_in_valid),
        .MISO_in             (MISO_in),
        .spi_clk             (spi_clk),
        .MOSI_out            (MOSI_out)
    );

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        int           load_cyc;
        int           rise_base;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            rise_cnt = 0;
    int            fall_cnt = 0;
    logic [63:0]   mosi_hist = '0;

    always @(posedge clk) cyc++;

    always @(posedge spi_clk) begin
        rise_cnt++;
        mosi_hist = {mosi_hist[62:0], MOSI_out};
    end

    always @(negedge spi_clk) fall_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Received word = the line level present at each of the W rising edges, MSB first.
    function automatic logic [W-1:0] ref_rx(input logic [W-1:0] tx, input logic [W-1:0] line_word);
        logic [W-1:0] rx;
        logic         b;
        rx = '0;
        for (int i = 0; i < W; i++) begin
            b  = LOOPBACK ? tx[W-1-i] : line_word[W-1-i];
            rx = {rx[W-2:0], b};
        end
        return rx;
    endfunction

    always @(negedge clk) begin
        if (data_in_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 64'(data_in_valid), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("miso_data", 64'(MISO_data), 64'(mon_e.rx));
                chk("ready_miso_set", 64'(transmit_ready_MISO), 64'(1));
                chk("mosi_bits", 64'(mosi_hist[W-1:0]), 64'(mon_e.tx));
                chk("spi_clk_pulses", 64'(rise_cnt - mon_e.rise_base), 64'(W));
                chk("shift_cycles", 64'(cyc - mon_e.load_cyc), 64'(SHIFT_CYC));
                chk("spi_clk_low_done", 64'(spi_clk), 64'(0));
            end
        end
    end

    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] line_word,
                        input bit junk, input int abort_bits);
        int           n;
        int           k;
        int           fb;
        logic [W-1:0] exp_rx;
        exp_t         e;
        n = 0;
        while (!transmit_ready_MOSI && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 64'(0), 64'(1));
        exp_rx              = ref_rx(tx, line_word);
        MOSI_data           = tx;
        data_transmit_valid = 1'b1;
        MISO_in             = line_word[W-1];
        e.tx                = tx;
        e.rx                = exp_rx;
        e.rise_base         = rise_cnt;
        fb                  = fall_cnt;
        @(negedge clk);
        e.load_cyc = cyc;
        chk("load_mosi_msb", 64'(MOSI_out), 64'(tx[W-1]));
        chk("busy_ready_low", 64'(transmit_ready_MOSI), 64'(0));
        chk("ready_miso_cleared", 64'(transmit_ready_MISO), 64'(0));
        if (abort_bits == 0) exp_q.push_back(e);
        if (junk) MOSI_data = 32'hDEADBEEF;
        else data_transmit_valid = 1'b0;

        if (abort_bits > 0) begin
            n = 0;
            while (!(fall_cnt - fb >= abort_bits && spi_clk) && n < SHIFT_CYC) begin
                @(negedge clk);
                k = fall_cnt - fb;
                MISO_in = (k < W) ? line_word[5'(W-1-k)] : 1'b0;
                n++;
            end
            if (n >= SHIFT_CYC) chk("abort_wait_timeout", 64'(0), 64'(1));
            rst = 1'b0;
            #1;
            chk("abort_spi_clk", 64'(spi_clk), 64'(0));
            chk("abort_ready_mosi", 64'(transmit_ready_MOSI), 64'(1));
            chk("abort_no_valid", 64'(data_in_valid), 64'(0));
            chk("abort_miso_data", 64'(MISO_data), 64'(0));
            data_transmit_valid = 1'b0;
            return;
        end

        n = 0;
        while (!data_in_valid && n < SHIFT_CYC + 20) begin
            @(negedge clk);
            k = fall_cnt - fb;
            MISO_in = (k < W) ? line_word[5'(W-1-k)] : 1'b0;
            n++;
        end
        if (!data_in_valid) chk("done_timeout", 64'(0), 64'(1));
        data_transmit_valid = 1'b0;
        @(negedge clk);
        chk("valid_one_cycle", 64'(data_in_valid), 64'(0));
        chk("ready_mosi_idle", 64'(transmit_ready_MOSI), 64'(1));
        chk("mosi_hold_idle", 64'(MOSI_out), 64'(tx[0]));
        repeat (5) @(negedge clk);
        chk("miso_data_hold", 64'(MISO_data), 64'(exp_rx));
        chk("ready_miso_hold", 64'(transmit_ready_MISO), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready_mosi", 64'(transmit_ready_MOSI), 64'(1));
        chk("rst_spi_clk", 64'(spi_clk), 64'(0));
        chk("rst_miso_data", 64'(MISO_data), 64'(0));
        chk("rst_data_in_valid", 64'(data_in_valid), 64'(0));
        chk("rst_ready_miso", 64'(transmit_ready_MISO), 64'(0));
        chk("rst_mosi_out", 64'(MOSI_out), 64'(0));
        rst = 1'b1;

        // Load on the very first edge after reset release.
        xfer(32'hA5A5F00F, 32'hFFFFFFFF, 1'b0, 0);
        xfer($urandom, 32'h12345678, 1'b0, 0);
        xfer(32'h00000001, $urandom, 1'b1, 0);
        xfer(32'hCAFEF00D, $urandom, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            xfer($urandom, $urandom, 1'(i % 2), 0);
        end

        xfer($urandom, $urandom, 1'b0, 10);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (SHIFT_CYC + 20) @(negedge clk);
        chk("post_abort_miso_data", 64'(MISO_data), 64'(0));
        chk("post_abort_ready_miso", 64'(transmit_ready_MISO), 64'(0));
        chk("post_abort_ready_mosi", 64'(transmit_ready_MOSI), 64'(1));

        xfer($urandom, $urandom, 1'b0, 0);
        repeat (4) @(negedge clk);
        chk("pending_expectations", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
